// File: rtl/reg_writeback_arbiter_pkg.sv
// reg_writeback_arbiter_pkg
// Purpose: shared widths, the buffered-result entry type and the arbitration
//          selection encoding used by the writeback arbiter and its FIFO.
// Contents: DATA_W, REG_NO_W, REG_ZERO, wb_entry_t, sel_e.
package reg_writeback_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_NO_W = 5;
  localparam logic [REG_NO_W-1:0] REG_ZERO = 5'd0;

  // One buffered multicycle result: destination register plus data.
  typedef struct packed {
    logic [REG_NO_W-1:0] rwNo;
    logic [DATA_W-1:0]   din;
  } wb_entry_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_ALU,
    SEL_FIFO,
    SEL_DRAIN
  } sel_e;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// reg_writeback_arbiter_if
// Purpose: bundles the ALU offer, the MDU valid/ready handshake, the decode
//          hazard lookups and the register-file write port.
// Modports: master = producer/decode/regfile side, slave = the arbiter.
interface reg_writeback_arbiter_if;
  import reg_writeback_arbiter_pkg::*;

  logic                alu_we;
  logic [REG_NO_W-1:0] alu_rw_no;
  logic [DATA_W-1:0]   alu_din;
  logic                alu_stall;

  logic                mdu_valid;
  logic [REG_NO_W-1:0] mdu_rw_no;
  logic [DATA_W-1:0]   mdu_din;
  logic                mdu_ready;

  logic [REG_NO_W-1:0] R1_no;
  logic [REG_NO_W-1:0] R2_no;
  logic [REG_NO_W-1:0] dst_no;
  logic                R1_pending;
  logic                R2_pending;
  logic                dst_pending;

  logic [REG_NO_W-1:0] RW_no;
  logic [DATA_W-1:0]   Din;
  logic                WE;

  modport master (
    output alu_we, alu_rw_no, alu_din, mdu_valid, mdu_rw_no, mdu_din,
           R1_no, R2_no, dst_no,
    input  alu_stall, mdu_ready, R1_pending, R2_pending, dst_pending,
           RW_no, Din, WE
  );

  modport slave (
    input  alu_we, alu_rw_no, alu_din, mdu_valid, mdu_rw_no, mdu_din,
           R1_no, R2_no, dst_no,
    output alu_stall, mdu_ready, R1_pending, R2_pending, dst_pending,
           RW_no, Din, WE
  );

endinterface

// File: rtl/reg_writeback_arbiter_wb_fifo.sv
// wb_fifo
// Purpose: DEPTH-entry in-order buffer of multicycle results waiting for the
//          register-file write port. Exposes per-entry valid/rw_no so the
//          parent can run hazard comparators against every buffered result.
// Ports: clk, reset (sync, active-low), i_push/i_pushEntry, i_pop,
//        o_head, o_empty, o_count, o_valid, o_rwNo.
module wb_fifo
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_push,
  input  wb_entry_t                        i_pushEntry,
  input  logic                             i_pop,
  output wb_entry_t                        o_head,
  output logic                             o_empty,
  output logic [$clog2(DEPTH):0]           o_count,
  output logic [DEPTH-1:0]                 o_valid,
  output logic [DEPTH-1:0][REG_NO_W-1:0]   o_rwNo
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]   r_valid;
  logic               w_full;
  logic               w_doPush;
  logic               w_doPop;

  // A push while full is refused even when a pop happens in the same cycle.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_doPush = i_push && !w_full;
  assign w_doPop  = i_pop && !o_empty;

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_head  = r_mem[r_rdPtr];

  // Pointers, occupancy and per-entry valid bits. A push into an empty FIFO
  // never aliases the pop slot because pop is blocked while empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_doPush) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= r_rdPtr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
    end
  end

  // Payload storage needs no reset; the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushEntry;
    end
  end

  // Flatten destination numbers for the parent's hazard comparators.
  always_comb begin
    o_rwNo = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_rwNo[i] = r_mem[i].rwNo;
    end
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
// Purpose: owns the register-file write port. Merges in-order ALU results with
//          buffered multicycle (MDU) results, with an anti-starvation drain,
//          and reports pending MDU destinations for decode hazard stalls.
// Ports: clk, reset (sync, active-low), bus (reg_writeback_arbiter_if.slave)
//        carrying the ALU offer, MDU handshake, lookups and RW_no/Din/WE.
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  reg_writeback_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  wb_entry_t                      w_head;
  wb_entry_t                      w_pushEntry;
  logic                           w_empty;
  logic                           w_full;
  logic [CNT_W-1:0]               w_count;
  logic [DEPTH-1:0]               w_entValid;
  logic [DEPTH-1:0][REG_NO_W-1:0] w_entRwNo;
  logic                           w_push;
  logic                           w_pop;
  sel_e                           w_sel;
  logic                           w_r1Hit;
  logic                           w_r2Hit;
  logic                           w_dstHit;

  logic [SW-1:0]       r_starveCnt;
  logic                r_we;
  logic [REG_NO_W-1:0] r_rwNo;
  logic [DATA_W-1:0]   r_din;
  logic                r_fromFifo;

  assign w_full        = (w_count == CNT_W'(DEPTH));
  assign bus.mdu_ready = reset && !w_full;
  // Results for r0 complete the handshake but are dropped here.
  assign w_push        = bus.mdu_valid && bus.mdu_ready && (bus.mdu_rw_no != REG_ZERO);
  assign w_pushEntry   = {bus.mdu_rw_no, bus.mdu_din};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pushEntry (w_pushEntry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_valid     (w_entValid),
    .o_rwNo      (w_entRwNo)
  );

  // Priority: forced drain after a starvation run, then a real ALU write,
  // then any buffered MDU result. An ALU offer to r0 falls through so the
  // FIFO may use the idle port.
  always_comb begin
    w_sel = SEL_IDLE;
    if (!reset) begin
      w_sel = SEL_IDLE;
    end else if (w_full && (r_starveCnt == SW'(STARVE_LIMIT))) begin
      w_sel = SEL_DRAIN;
    end else if (bus.alu_we && (bus.alu_rw_no != REG_ZERO)) begin
      w_sel = SEL_ALU;
    end else if (!w_empty) begin
      w_sel = SEL_FIFO;
    end
  end

  assign w_pop         = (w_sel == SEL_DRAIN) || (w_sel == SEL_FIFO);
  assign bus.alu_stall = (w_sel == SEL_DRAIN);

  // Counts ALU wins only while the FIFO stays full; any other outcome resets
  // the run so the drain fires after STARVE_LIMIT consecutive losses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starveCnt <= '0;
    end else if (w_sel == SEL_ALU) begin
      if (!w_full) begin
        r_starveCnt <= '0;
      end else if (r_starveCnt != SW'(STARVE_LIMIT)) begin
        r_starveCnt <= r_starveCnt + SW'(1);
      end
    end else begin
      r_starveCnt <= '0;
    end
  end

  // Registered write port. r_fromFifo marks writes that still count as
  // pending for hazard lookups until the register file has captured them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_rwNo     <= REG_ZERO;
      r_din      <= '0;
      r_fromFifo <= 1'b0;
    end else begin
      case (w_sel)
        SEL_ALU: begin
          r_we       <= 1'b1;
          r_rwNo     <= bus.alu_rw_no;
          r_din      <= bus.alu_din;
          r_fromFifo <= 1'b0;
        end
        SEL_FIFO, SEL_DRAIN: begin
          r_we       <= 1'b1;
          r_rwNo     <= w_head.rwNo;
          r_din      <= w_head.din;
          r_fromFifo <= 1'b1;
        end
        default: begin
          r_we       <= 1'b0;
          r_fromFifo <= 1'b0;
        end
      endcase
    end
  end

  assign bus.WE    = r_we;
  assign bus.RW_no = r_rwNo;
  assign bus.Din   = r_din;

  // Compare each lookup against every valid buffered destination.
  always_comb begin
    w_r1Hit  = 1'b0;
    w_r2Hit  = 1'b0;
    w_dstHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entValid[i] && (w_entRwNo[i] == bus.R1_no))  w_r1Hit  = 1'b1;
      if (w_entValid[i] && (w_entRwNo[i] == bus.R2_no))  w_r2Hit  = 1'b1;
      if (w_entValid[i] && (w_entRwNo[i] == bus.dst_no)) w_dstHit = 1'b1;
    end
  end

  assign bus.R1_pending  = (bus.R1_no != REG_ZERO) &&
                           (w_r1Hit || (r_we && r_fromFifo && (r_rwNo == bus.R1_no)));
  assign bus.R2_pending  = (bus.R2_no != REG_ZERO) &&
                           (w_r2Hit || (r_we && r_fromFifo && (r_rwNo == bus.R2_no)));
  assign bus.dst_pending = (bus.dst_no != REG_ZERO) &&
                           (w_dstHit || (r_we && r_fromFifo && (r_rwNo == bus.dst_no)));

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// tb_reg_writeback_arbiter
// Purpose: drives directed and randomized ALU/MDU traffic into
//          reg_writeback_arbiter and compares the write port, handshake,
//          stall and hazard lookups against a queue-based reference model.
module tb_reg_writeback_arbiter;
  import reg_writeback_arbiter_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] din;
  } ent_t;

  logic clk;
  logic reset;

  reg_writeback_arbiter_if bus();

  reg_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;

  // Reference model state: buffered MDU results in arrival order, length of
  // the current ALU-wins-while-full run, and the last write-port contents.
  ent_t        mq[$];
  int          starve = 0;
  logic        lastWe = 1'b0;
  logic [4:0]  lastRw = 5'd0;
  logic [31:0] lastDin = 32'd0;
  logic        lastFromFifo = 1'b0;

  // Per-cycle expectations for the write port, consumed by the monitor.
  logic [37:0] expq[$];

  logic expReady, expStall, expR1, expR2, expDst, mduAccepted;

  task automatic checkOutput(input string name, input logic [37:0] act, input logic [37:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic modelPending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rw == r) return 1'b1;
    return lastFromFifo && (lastRw == r);
  endfunction

  // One clock cycle: drive inputs, advance the model, then check the
  // combinational outputs at the falling edge.
  task automatic applyStimulus(input logic rstN, input logic aluWe, input logic [4:0] aluRw,
                               input logic [31:0] aluDin, input logic mduValid,
                               input logic [4:0] mduRw, input logic [31:0] mduDin,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dst);
    logic full;
    ent_t head;
    @(posedge clk);
    #1;
    reset         = rstN;
    bus.alu_we    = aluWe;
    bus.alu_rw_no = aluRw;
    bus.alu_din   = aluDin;
    bus.mdu_valid = mduValid;
    bus.mdu_rw_no = mduRw;
    bus.mdu_din   = mduDin;
    bus.R1_no     = r1;
    bus.R2_no     = r2;
    bus.dst_no    = dst;

    expR1  = modelPending(r1);
    expR2  = modelPending(r2);
    expDst = modelPending(dst);

    if (!rstN) begin
      expReady     = 1'b0;
      expStall     = 1'b0;
      mduAccepted  = 1'b0;
      mq.delete();
      starve       = 0;
      lastWe       = 1'b0;
      lastRw       = 5'd0;
      lastDin      = 32'd0;
      lastFromFifo = 1'b0;
    end else begin
      full        = (mq.size() == DEPTH);
      expReady    = !full;
      mduAccepted = mduValid && !full;
      expStall    = 1'b0;
      if (full && starve == STARVE_LIMIT) begin
        expStall = 1'b1;
        head = mq.pop_front();
        lastWe = 1'b1; lastRw = head.rw; lastDin = head.din; lastFromFifo = 1'b1;
        starve = 0;
      end else if (aluWe && aluRw != 5'd0) begin
        lastWe = 1'b1; lastRw = aluRw; lastDin = aluDin; lastFromFifo = 1'b0;
        starve = full ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
      end else if (mq.size() > 0) begin
        head = mq.pop_front();
        lastWe = 1'b1; lastRw = head.rw; lastDin = head.din; lastFromFifo = 1'b1;
        starve = 0;
      end else begin
        lastWe = 1'b0; lastFromFifo = 1'b0;
        starve = 0;
      end
      if (mduAccepted && mduRw != 5'd0) mq.push_back('{rw: mduRw, din: mduDin});
    end
    expq.push_back({lastWe, lastRw, lastDin});

    @(negedge clk);
    checkOutput("mdu_ready",   {37'd0, bus.mdu_ready},   {37'd0, expReady});
    checkOutput("alu_stall",   {37'd0, bus.alu_stall},   {37'd0, expStall});
    checkOutput("R1_pending",  {37'd0, bus.R1_pending},  {37'd0, expR1});
    checkOutput("R2_pending",  {37'd0, bus.R2_pending},  {37'd0, expR2});
    checkOutput("dst_pending", {37'd0, bus.dst_pending}, {37'd0, expDst});
  endtask

  // Monitor: the expectation pushed in the previous cycle describes the
  // write port visible during the current cycle.
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (expq.size() >= 2) begin
        e = expq.pop_front();
        checkOutput("wb_port", {bus.WE, bus.RW_no, bus.Din}, e);
      end
    end
  end

  task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] dst);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, r1, 0, dst);
  endtask

  initial begin
    logic        got14;
    logic        hAlu, hMdu;
    logic        aWe, mV, rstN;
    logic [4:0]  aRw, mRw;
    logic [31:0] aDin, mDin;

    reset = 1'b0;
    bus.alu_we = 0; bus.alu_rw_no = 0; bus.alu_din = 0;
    bus.mdu_valid = 0; bus.mdu_rw_no = 0; bus.mdu_din = 0;
    bus.R1_no = 0; bus.R2_no = 0; bus.dst_no = 0;

    $display("[TB] reset held with mdu_valid asserted");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'h7777, 7, 0, 7);
    idle(2, 7, 7);

    $display("[TB] single ALU write");
    applyStimulus(1, 1, 8, 32'h1234, 0, 0, 0, 0, 0, 0);
    idle(1, 8, 8);

    $display("[TB] ALU and MDU in the same cycle");
    applyStimulus(1, 1, 3, 32'h3333, 1, 9, 32'hBEEF, 9, 3, 9);
    idle(4, 9, 9);

    $display("[TB] starvation drain");
    got14 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i < 4)
        applyStimulus(1, 1, 20, 32'hA5A5, 1, 5'(10 + i), 32'h1000 + i, 10, 11, 12);
      else if (!got14)
        applyStimulus(1, 1, 20, 32'hA5A5, 1, 14, 32'h1014, 10, 11, 14);
      else
        applyStimulus(1, 1, 20, 32'hA5A5, 0, 0, 0, 12, 13, 14);
      if (i >= 4 && mduAccepted) got14 = 1'b1;
    end
    idle(8, 13, 14);

    $display("[TB] writes to r0 from both sources");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'hDEAD, 1, 0, 32'hF00D, 0, 0, 0);
    idle(1, 0, 0);

    $display("[TB] reset while FIFO holds an entry");
    applyStimulus(1, 1, 6, 32'h66, 1, 5, 32'h55, 5, 0, 5);
    applyStimulus(1, 1, 6, 32'h67, 0, 0, 0, 5, 0, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0, 5);
    idle(4, 5, 5);

    $display("[TB] randomized traffic");
    hAlu = 0; hMdu = 0;
    aWe = 0; aRw = 0; aDin = 0; mV = 0; mRw = 0; mDin = 0;
    for (int i = 0; i < 500; i++) begin
      rstN = ($urandom_range(0, 149) != 0);
      if (!hAlu) begin
        aWe  = ((i / 50) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
        aRw  = 5'($urandom_range(0, 15));
        aDin = $urandom;
      end
      if (!hMdu) begin
        mV   = ($urandom_range(0, 2) == 0);
        mRw  = 5'($urandom_range(0, 15));
        mDin = $urandom;
      end
      applyStimulus(rstN, aWe, aRw, aDin, mV, mRw, mDin,
                    5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                    5'($urandom_range(0, 15)));
      hAlu = rstN && aWe && expStall;
      hMdu = rstN && mV && !mduAccepted;
    end
    idle(12, 0, 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
